enemy_run_sequencer: RTL and testbench

- Sequences one green running enemy sprite: spawn, walk left/right across the 640x480 screen, cycle the running animation frames, play a death hold, return to idle.
- Per-pixel side: computes sprite-local ROM address and an in-sprite flag for the current DrawX/DrawY.
- Outputs are registered once to align with the one-cycle latency of the sprite ROMs.
- Sits between the game/collision logic and the per-frame sprite mappers; the top level uses frame_sel to mux mapper palette outputs.

---
 rtl/enemy_run_sequencer.sv | 134 +++++++++++++
 tb/tb_enemy_run_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/enemy_run_sequencer.sv
// Single running-enemy sequencer: spawn, walk, animate, die, plus the per-pixel
// sprite ROM address and in-sprite flag, registered to match the ROM latency.
module enemy_run_sequencer #(
    parameter int unsigned SPRITE_W   = 40,
    parameter int unsigned SPRITE_H   = 66,
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned NUM_FRAMES = 6,
    parameter int unsigned FRAME_HOLD = 4,
    parameter int unsigned SPEED      = 2,
    parameter int unsigned DIE_HOLD   = 30,
    parameter int unsigned ENEMY_Y    = 300
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        spawn,
    input  logic [9:0]  spawn_x,
    input  logic        spawn_dir,
    input  logic        kill,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    output logic        active,
    output logic        dying,
    output logic [2:0]  frame_sel,
    output logic [9:0]  enemy_x,
    output logic [11:0] rom_address,
    output logic        in_sprite
);

    localparam int unsigned HOLD_MAX = (DIE_HOLD > FRAME_HOLD) ? DIE_HOLD : FRAME_HOLD;
    localparam int unsigned HW       = $clog2(HOLD_MAX);
    localparam logic [9:0]  X_MAX    = 10'(SCREEN_W - SPRITE_W);

    typedef enum logic [1:0] {StIdle, StRun, StDying} state_e;

    state_e          state_q, state_d;
    logic            dir_q, dir_d;
    logic [2:0]      frame_q, frame_d;
    logic [9:0]      x_q, x_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            leave;

    logic            in_box;
    logic [10:0]     x_hi;
    logic [11:0]     dx, dy, addr_d;

    // A move that would push any part of the sprite off-screen ends the run instead.
    assign leave = dir_q ? (({1'b0, x_q} + 11'(SPEED)) > {1'b0, X_MAX})
                         : (x_q < 10'(SPEED));

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        frame_d = frame_q;
        x_d     = x_q;
        hold_d  = hold_q;
        case (state_q)
            StIdle: begin
                if (spawn) begin
                    state_d = StRun;
                    x_d     = (spawn_x > X_MAX) ? X_MAX : spawn_x;
                    dir_d   = spawn_dir;
                    frame_d = '0;
                    hold_d  = '0;
                end
            end
            StRun: begin
                if (kill) begin
                    state_d = StDying;
                    hold_d  = '0;
                end else if (frame_start) begin
                    if (leave) begin
                        state_d = StIdle;
                    end else begin
                        x_d = dir_q ? (x_q + 10'(SPEED)) : (x_q - 10'(SPEED));
                        if (hold_q == HW'(FRAME_HOLD - 1)) begin
                            hold_d  = '0;
                            frame_d = (frame_q == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame_q + 3'd1;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
            end
            StDying: begin
                if (frame_start) begin
                    if (hold_q == HW'(DIE_HOLD - 1)) begin
                        state_d = StIdle;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        x_hi   = {1'b0, x_q} + 11'(SPRITE_W - 1);
        in_box = (DrawX >= x_q) && ({1'b0, DrawX} <= x_hi) &&
                 (DrawY >= 10'(ENEMY_Y)) && ({1'b0, DrawY} <= 11'(ENEMY_Y + SPRITE_H - 1));
        dx     = 12'(DrawX - x_q);
        dy     = 12'(DrawY - 10'(ENEMY_Y));
        addr_d = in_box ? (dy * 12'(SPRITE_W) + dx) : 12'd0;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            dir_q       <= 1'b0;
            frame_q     <= '0;
            x_q         <= '0;
            hold_q      <= '0;
            rom_address <= '0;
            in_sprite   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            frame_q     <= frame_d;
            x_q         <= x_d;
            hold_q      <= hold_d;
            rom_address <= addr_d;
            in_sprite   <= in_box && blank && (state_q != StIdle);
        end
    end

    assign active    = (state_q != StIdle);
    assign dying     = (state_q == StDying);
    assign frame_sel = frame_q;
    assign enemy_x   = x_q;

endmodule

// File: tb/tb_enemy_run_sequencer.sv
// Bench for enemy_run_sequencer: hand sequences for motion/animation/death and a
// vector table for the pixel path checked through an expected-value queue.
module tb_enemy_run_sequencer;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        spawn = 1'b0;
    logic [9:0]  spawn_x = '0;
    logic        spawn_dir = 1'b0;
    logic        kill = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        blank = 1'b0;
    logic        active, dying, in_sprite;
    logic [2:0]  frame_sel;
    logic [9:0]  enemy_x;
    logic [11:0] rom_address;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic        blk;
        logic [11:0] exp_addr;
        logic        exp_in;
    } pix_vec_t;

    typedef struct {
        logic [11:0] addr;
        logic        ins;
    } exp_t;

    exp_t sb[$];

    enemy_run_sequencer dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .spawn      (spawn),
        .spawn_x    (spawn_x),
        .spawn_dir  (spawn_dir),
        .kill       (kill),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .active     (active),
        .dying      (dying),
        .frame_sel  (frame_sel),
        .enemy_x    (enemy_x),
        .rom_address(rom_address),
        .in_sprite  (in_sprite)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic do_spawn(input int x, input logic dir);
        spawn     = 1'b1;
        spawn_x   = 10'(x);
        spawn_dir = dir;
        tick();
        spawn = 1'b0;
    endtask

    pix_vec_t vecs[9];

    initial begin
        vecs[0] = '{10'd139, 10'd365, 1'b1, 12'd2639, 1'b1};
        vecs[1] = '{10'd140, 10'd365, 1'b1, 12'd0,    1'b0};
        vecs[2] = '{10'd139, 10'd365, 1'b0, 12'd2639, 1'b0};
        vecs[3] = '{10'd100, 10'd300, 1'b1, 12'd0,    1'b1};
        vecs[4] = '{10'd99,  10'd300, 1'b1, 12'd0,    1'b0};
        vecs[5] = '{10'd100, 10'd299, 1'b1, 12'd0,    1'b0};
        vecs[6] = '{10'd110, 10'd301, 1'b1, 12'd50,   1'b1};
        vecs[7] = '{10'd120, 10'd366, 1'b1, 12'd0,    1'b0};
        vecs[8] = '{10'd125, 10'd320, 1'b1, 12'd825,  1'b1};

        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("reset_active", int'(active), 0);
        check("reset_enemy_x", int'(enemy_x), 0);
        check("reset_frame_sel", int'(frame_sel), 0);

        // Frame_start in idle does nothing
        pulse_frame();
        check("idle_frame_active", int'(active), 0);

        // Spawn with simultaneous kill: kill ignored
        kill = 1'b1;
        do_spawn(100, 1'b1);
        kill = 1'b0;
        check("spawn_active", int'(active), 1);
        check("spawn_kill_ignored", int'(dying), 0);
        check("spawn_x", int'(enemy_x), 100);

        // Pixel path table with enemy_x = 100
        foreach (vecs[i]) begin
            DrawX = vecs[i].dx;
            DrawY = vecs[i].dy;
            blank = vecs[i].blk;
            sb.push_back('{vecs[i].exp_addr, vecs[i].exp_in});
            tick();
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("pix%0d_addr", i), int'(rom_address), int'(e.addr));
                check($sformatf("pix%0d_in", i), int'(in_sprite), int'(e.ins));
            end
        end

        // Animate: 8 pulses then up to 24
        for (int p = 1; p <= 24; p++) begin
            pulse_frame();
            if (p == 3) check("anim_p3_frame", int'(frame_sel), 0);
            if (p == 4) check("anim_p4_frame", int'(frame_sel), 1);
            if (p == 7) check("anim_p7_frame", int'(frame_sel), 1);
            if (p == 8) begin
                check("anim_p8_frame", int'(frame_sel), 2);
                check("anim_p8_x", int'(enemy_x), 116);
            end
            if (p == 20) check("anim_p20_frame", int'(frame_sel), 5);
        end
        check("wrap_frame", int'(frame_sel), 0);
        check("wrap_x", int'(enemy_x), 148);

        // Async reset mid-run, with a pixel inside the sprite
        DrawX = 150;
        DrawY = 310;
        blank = 1'b1;
        tick();
        check("pre_reset_in_sprite", int'(in_sprite), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_active", int'(active), 0);
        check("async_rst_x", int'(enemy_x), 0);
        check("async_rst_frame", int'(frame_sel), 0);
        check("async_rst_in_sprite", int'(in_sprite), 0);
        check("async_rst_addr", int'(rom_address), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_idle", int'(active), 0);
        blank = 1'b0;

        // Left edge exit
        do_spawn(3, 1'b0);
        pulse_frame();
        check("left_x1", int'(enemy_x), 1);
        check("left_still_active", int'(active), 1);
        pulse_frame();
        check("left_exit_active", int'(active), 0);
        check("left_exit_x", int'(enemy_x), 1);

        // Spawn clamp and right edge exit
        do_spawn(700, 1'b1);
        check("clamp_x", int'(enemy_x), 600);
        pulse_frame();
        check("right_exit_active", int'(active), 0);
        check("right_exit_x", int'(enemy_x), 600);

        // Kill coincident with frame_start at x=200, frame 3
        do_spawn(176, 1'b1);
        repeat (12) pulse_frame();
        check("prekill_x", int'(enemy_x), 200);
        check("prekill_frame", int'(frame_sel), 3);
        kill = 1'b1;
        pulse_frame();
        kill = 1'b0;
        check("kill_dying", int'(dying), 1);
        check("kill_x", int'(enemy_x), 200);
        check("kill_frame", int'(frame_sel), 3);
        do_spawn(50, 1'b0);
        check("dying_spawn_ignored", int'(dying), 1);
        check("dying_spawn_x", int'(enemy_x), 200);
        for (int p = 1; p <= 30; p++) begin
            if (p == 10) begin
                kill = 1'b1;
                tick();
                kill = 1'b0;
            end
            pulse_frame();
            if (p == 29) check("die_p29_dying", int'(dying), 1);
        end
        check("die_done_dying", int'(dying), 0);
        check("die_done_active", int'(active), 0);
        check("die_frame_kept", int'(frame_sel), 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
